branch_compare_seq: RTL and testbench
=====================================

// Module: branch_compare_seq
// PURPOSE
//  Multi-cycle, parametrised branch comparator for stage 2 (branch resolution).
//  Compares rs1d/rs2d CHUNK bits per cycle, MSB chunk first, with optional early exit.
//  Decodes funct3 into a taken decision. Valid/ready on both sides.
//  Decouples wide compares from the stage-2 critical path.
// PARAMETERS
//  WIDTH      32  operand width; must be a multiple of CHUNK
//  CHUNK       8  bits compared per cycle; NCH = WIDTH/CHUNK, NCH >= 1
//  EARLY_EXIT  1  1: finish at the first differing chunk; 0: always scan all NCH chunks
// PORTS
//  clk        in   1      clock; all state on posedge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      block can accept a request this cycle
//  rs1d       in   WIDTH  rs1 data
//  rs2d       in   WIDTH  rs2 data
//  funct3     in   3      branch type: BEQ=000 BNE=001 BLT=100 BGE=101 BLTU=110 BGEU=111
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts the result
//  eq         out  1      rs1d == rs2d
//  lt         out  1      rs1d < rs2d; signed for 10x, unsigned for 11x
//  taken      out  1      branch decision per funct3
//  illegal    out  1      funct3 was 010 or 011; taken=0
// BEHAVIOUR
//  - FSM states: IDLE, CMP, DONE. rst forces IDLE asynchronously, mid-operation included.
//    The in-flight request is dropped.
//  - Reset values: out_valid=0, eq=0, lt=0, taken=0, illegal=0. in_ready=1 after rst deasserts.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready). Accept on in_valid & in_ready.
//    Acceptance in DONE with out_ready gives back-to-back operation with no bubble.
//  - On accept: latch operands and funct3, set idx=NCH-1, enter CMP.
//    For signed types (funct3[2:1]==2'b10), invert bit WIDTH-1 of both latched operands.
//    This bias makes the chunk compare purely unsigned.
//  - CMP, each cycle: compare chunk idx of A and B.
//    - First differing chunk: record lt = A_chunk < B_chunk and eq=0.
//      If EARLY_EXIT=1, go to DONE; otherwise keep scanning.
//      Later chunks never overwrite the first recorded difference.
//    - idx==0 and no difference seen: eq=1, lt=0, go to DONE.
//    - idx decrements by 1 per cycle; it never wraps below 0.
//  - Latency, accept edge to out_valid: EARLY_EXIT=1 gives k cycles (k = chunks examined, 1..NCH).
//    EARLY_EXIT=0 gives exactly NCH cycles.
//  - taken: BEQ=eq, BNE=~eq, BLT/BLTU=lt, BGE/BGEU=~lt.
//    funct3 010/011: illegal=1, taken=0; eq/lt still computed.
//  - eq, lt, taken, illegal are registered; they update only on the transition into DONE.
//    They stay stable while out_valid=1 and out_ready=0.
//  - DONE: out_valid=1. out_ready & ~in_valid -> IDLE with out_valid=0.
//    out_ready & in_valid -> CMP with the new request.
//  - in_valid while busy in CMP: ignored (in_ready=0). Upstream must hold the request.
//  - NCH=1: a single CMP cycle, so latency is 1 cycle.
// STRUCTURE
//  - Shared package branch_pkg: funct3 localparams (BEQ..BGEU) and the 2-bit FSM state encoding.
//  - Sub-module chunk_cmp #(CHUNK): combinational a,b -> eq,lt, unsigned.
//    One instance, muxed by idx.
//  - idx counter width is $clog2(NCH), minimum 1 bit.
// TESTING
//  1. BEQ, rs1d=rs2d=32'hDEADBEEF, EARLY_EXIT=1
//     -> out_valid after 4 cycles; eq=1, lt=0, taken=1.
//  2. BLT, rs1d=32'hFFFFFFFF (-1), rs2d=32'h00000001
//     -> lt=1, taken=1 after 1 cycle (early exit on MSB chunk).
//  3. BLTU with the same operands as test 2 -> lt=0, eq=0, taken=0 after 1 cycle.
//     Repeat with EARLY_EXIT=0 -> same result after 4 cycles.
//  4. BGE, rs1d=32'h12345600, rs2d=32'h12345601 -> lt=1, taken=0 after 4 cycles.
//     Then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
//  5. Back-to-back: out_ready=1 with in_valid=1 in DONE (BNE 5 vs 5, then BNE 5 vs 6)
//     -> second request accepted the same cycle; taken=0, then taken=1.
//  6. Assert rst mid-CMP -> out_valid=0 immediately; in_ready=1 after release.
//     Also funct3=3'b010 -> illegal=1, taken=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the sequential branch comparator.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed compares are turned into unsigned ones by flipping the sign bit.
  function automatic logic f3_signed(input logic [2:0] f3);
    return f3[2:1] == 2'b10;
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

  function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    t = 1'b0;
    case (f3)
      BEQ:         t = eq;
      BNE:         t = ~eq;
      BLT, BLTU:   t = lt;
      BGE, BGEU:   t = ~lt;
      default:     t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Unsigned equality / less-than on one CHUNK-bit slice.
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/branch_compare_seq.sv
// Multi-cycle branch comparator: scans operands one chunk per cycle, MSB first.
module branch_compare_seq
  import branch_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1d,
  input  logic [WIDTH-1:0] rs2d,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             taken,
  output logic             illegal
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       f3;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q, req_in;
  logic [IW-1:0] idx;
  logic   diff_seen, lt_acc;
  logic   accept;

  logic [NCH-1:0][CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK-1:0] a_sel, b_sel;
  logic   ch_eq, ch_lt;
  logic   first_diff, fin, fin_eq, fin_lt;

  assign a_ch  = req_q.a;
  assign b_ch  = req_q.b;
  assign a_sel = a_ch[idx];
  assign b_sel = b_ch[idx];

  chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
    .a  (a_sel),
    .b  (b_sel),
    .eq (ch_eq),
    .lt (ch_lt)
  );

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);

  // Only the first differing chunk decides lt; later chunks are ignored.
  assign first_diff = ~diff_seen & ~ch_eq;
  assign fin        = (state == CMP) &
                      (((EARLY_EXIT != 0) & first_diff) | (idx == '0));
  assign fin_eq     = ~diff_seen & ch_eq;
  assign fin_lt     = first_diff ? ch_lt : (diff_seen & lt_acc);

  // Operand capture with sign-bit bias for signed branch types.
  always_comb begin
    req_in    = '{a: rs1d, b: rs2d, f3: funct3};
    if (f3_signed(funct3)) begin
      req_in.a[WIDTH-1] = ~rs1d[WIDTH-1];
      req_in.b[WIDTH-1] = ~rs2d[WIDTH-1];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CMP;
      CMP:     if (fin)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? CMP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, chunk index, first-difference tracking, results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      idx       <= '0;
      diff_seen <= 1'b0;
      lt_acc    <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      taken     <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      req_q     <= req_in;
      idx       <= IW'(NCH - 1);
      diff_seen <= 1'b0;
      lt_acc    <= 1'b0;
    end else if (state == CMP) begin
      if (first_diff) begin
        diff_seen <= 1'b1;
        lt_acc    <= ch_lt;
      end
      if (!fin && idx != '0) idx <= idx - 1'b1;
      if (fin) begin
        eq      <= fin_eq;
        lt      <= fin_lt;
        taken   <= ~f3_illegal(req_q.f3) & f3_taken(req_q.f3, fin_eq, fin_lt);
        illegal <= f3_illegal(req_q.f3);
      end
    end
  end

endmodule

// File: tb/tb_branch_compare_seq.sv
// Directed bench: table of vectors run on an early-exit and a full-scan instance.
module tb_branch_compare_seq;

  logic        clk, rst;
  logic        in_valid, out_ready;
  logic [31:0] rs1d, rs2d;
  logic [2:0]  funct3;
  logic        in_ready, out_valid, eq, lt, taken, illegal;
  logic        in_ready0, out_valid0, eq0, lt0, taken0, illegal0;

  int n_cmp = 0;
  int n_err = 0;

  branch_compare_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1d(rs1d), .rs2d(rs2d), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .eq(eq), .lt(lt), .taken(taken), .illegal(illegal)
  );

  branch_compare_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .rs1d(rs1d), .rs2d(rs2d), .funct3(funct3),
    .out_valid(out_valid0), .out_ready(out_ready),
    .eq(eq0), .lt(lt0), .taken(taken0), .illegal(illegal0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        eq, lt, taken, illegal;
    int          lat_ee;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("in_ready_before_issue", {in_ready, in_ready0}, 2'b11);
    in_valid = 1'b1; funct3 = f3; rs1d = a; rs2d = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until each instance raises out_valid.
  task automatic wait_done(output int l1, output int l0);
    bit g1, g0;
    int n;
    g1 = 0; g0 = 0; l1 = -1; l0 = -1; n = 0;
    while (!(g1 && g0) && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (out_valid  && !g1) begin g1 = 1; l1 = n; end
      if (out_valid0 && !g0) begin g0 = 1; l0 = n; end
    end
    if (!(g1 && g0)) chk("timeout_out_valid", {31'd0, g1 & g0}, 32'd1);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_release", {out_valid, out_valid0}, 2'b00);
  endtask

  initial begin
    int l1, l0;
    logic [3:0] snap;

    vecs[0] = '{3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 1, 0, 4};
    vecs[1] = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 0, 1, 1, 0, 1};
    vecs[2] = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, 1};
    vecs[3] = '{3'b101, 32'h12345600, 32'h12345601, 0, 1, 0, 0, 4};
    vecs[4] = '{3'b111, 32'h00010000, 32'h00020000, 0, 1, 0, 0, 2};
    vecs[5] = '{3'b100, 32'h80000000, 32'h7FFFFFFF, 0, 1, 1, 0, 1};
    vecs[6] = '{3'b110, 32'h02000000, 32'h01FFFFFF, 0, 0, 0, 0, 1};
    vecs[7] = '{3'b010, 32'h00000003, 32'h00000003, 1, 0, 0, 1, 4};
    vecs[8] = '{3'b011, 32'h00000001, 32'h00000002, 0, 1, 0, 1, 4};
    vecs[9] = '{3'b101, 32'h7FFFFFFF, 32'h80000000, 0, 0, 1, 0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rs1d = '0; rs2d = '0; funct3 = '0;
    #12;
    chk("reset_outputs", {out_valid, eq, lt, taken, illegal}, 5'b0);
    chk("reset_outputs_full", {out_valid0, eq0, lt0, taken0, illegal0}, 5'b0);
    @(negedge clk); rst = 1'b0;
    #1 chk("in_ready_after_reset", {in_ready, in_ready0}, 2'b11);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b);
      wait_done(l1, l0);
      chk($sformatf("v%0d_lat_ee", i), l1, vecs[i].lat_ee);
      chk($sformatf("v%0d_lat_full", i), l0, 4);
      chk($sformatf("v%0d_ee_flags", i), {eq, lt, taken, illegal},
          {vecs[i].eq, vecs[i].lt, vecs[i].taken, vecs[i].illegal});
      chk($sformatf("v%0d_full_flags", i), {eq0, lt0, taken0, illegal0},
          {vecs[i].eq, vecs[i].lt, vecs[i].taken, vecs[i].illegal});
      release_result();
    end

    // Stall: hold out_ready low with a pending new request; result must not move.
    issue(3'b101, 32'h12345600, 32'h12345601);
    wait_done(l1, l0);
    snap = {eq, lt, taken, illegal};
    chk("stall_flags", snap, 4'b0100);
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b000; rs1d = 32'h1; rs2d = 32'h1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_c%0d", c), {out_valid, in_ready, eq, lt, taken, illegal},
          {1'b1, 1'b0, snap});
    end
    @(negedge clk); in_valid = 1'b0;
    release_result();

    // Back-to-back: BNE 5,5 then BNE 5,6 accepted in the DONE cycle.
    issue(3'b001, 32'd5, 32'd5);
    wait_done(l1, l0);
    @(negedge clk);
    chk("b2b_first_taken", {eq, taken}, 2'b10);
    in_valid = 1'b1; funct3 = 3'b001; rs1d = 32'd5; rs2d = 32'd6; out_ready = 1'b1;
    #1 chk("b2b_in_ready_done", {in_ready, in_ready0}, 2'b11);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_accepted", {out_valid, in_ready}, 2'b00);
    wait_done(l1, l0);
    chk("b2b_second_lat", l1, 4);
    chk("b2b_second_taken", {eq, taken, eq0, taken0}, 4'b0101);
    release_result();

    // Reset mid-CMP drops the request.
    issue(3'b000, 32'hA5A5A5A5, 32'hA5A5A5A5);
    @(negedge clk); rst = 1'b1;
    #1 chk("rst_mid_cmp_out_valid", {out_valid, out_valid0}, 2'b00);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_mid_cmp_in_ready", {in_ready, in_ready0}, 2'b11);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_dropped_c%0d", c), {out_valid, out_valid0}, 2'b00);
    end

    // Reset while a result is held clears it at once.
    issue(3'b000, 32'h0F0F0F0F, 32'h0F0F0F0F);
    wait_done(l1, l0);
    chk("pre_rst_done_taken", {out_valid, taken}, 2'b11);
    @(negedge clk); rst = 1'b1;
    #1 chk("rst_done_clear", {out_valid, eq, lt, taken, illegal}, 5'b0);
    @(negedge clk); rst = 1'b0;

    // Fresh transaction after reset still works.
    issue(3'b100, 32'hFFFFFFFF, 32'h00000001);
    wait_done(l1, l0);
    chk("post_rst_lat", l1, 1);
    chk("post_rst_flags", {eq, lt, taken, illegal}, 4'b0110);
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
